// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state encoding
// and grant-owner constants.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INST = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

   localparam logic [3:0] INST_MASK = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data access) arbiter onto one shared
// memory port; one outstanding transaction, alternating grant under contention.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter bit DATA_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ip_inst_req,
   input  logic [31:0] ip_inst_addr,
   output logic        op_inst_valid,
   output logic [31:0] op_inst_data,
   input  logic        ip_data_rd,
   input  logic        ip_data_wr,
   input  logic [31:0] ip_data_addr,
   input  logic [3:0]  ip_data_mask,
   input  logic [31:0] ip_data_wdata,
   output logic        op_data_valid,
   output logic [31:0] op_data_rdata,
   output logic        op_mem_req,
   output logic        op_mem_wr,
   output logic [31:0] op_mem_addr,
   output logic [3:0]  op_mem_mask,
   output logic [31:0] op_mem_wdata,
   input  logic        ip_mem_ack,
   input  logic [31:0] ip_mem_rdata
);

   state_e      state_q;
   owner_e      last_q;
   logic        first_q;
   logic        mem_req_q, mem_wr_q;
   logic [31:0] mem_addr_q, mem_wdata_q;
   logic [3:0]  mem_mask_q;
   logic        inst_valid_q, data_valid_q;
   logic [31:0] inst_data_q, data_rdata_q;

   logic        inst_pend, data_pend;
   logic        grant_inst_d, grant_data_d;

   // A requester still sees its own request high during its valid cycle;
   // that level belongs to the finished transaction and must not regrant.
   always_comb begin
      inst_pend    = ip_inst_req && !inst_valid_q;
      data_pend    = (ip_data_rd || ip_data_wr) && !data_valid_q;
      grant_inst_d = 1'b0;
      grant_data_d = 1'b0;
      if (state_q == ST_IDLE) begin
         if (inst_pend && data_pend) begin
            grant_data_d = first_q ? DATA_FIRST : (last_q == OWN_INST);
            grant_inst_d = !grant_data_d;
         end else begin
            grant_inst_d = inst_pend;
            grant_data_d = data_pend;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_q       <= OWN_INST;
         first_q      <= 1'b1;
         mem_req_q    <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_mask_q   <= 4'd0;
         mem_wdata_q  <= 32'd0;
         inst_valid_q <= 1'b0;
         data_valid_q <= 1'b0;
         inst_data_q  <= 32'd0;
         data_rdata_q <= 32'd0;
      end else begin
         inst_valid_q <= 1'b0;
         data_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_data_d) begin
                  state_q     <= ST_DATA;
                  last_q      <= OWN_DATA;
                  first_q     <= 1'b0;
                  mem_req_q   <= 1'b1;
                  mem_wr_q    <= ip_data_wr;
                  mem_addr_q  <= ip_data_addr;
                  mem_mask_q  <= ip_data_mask;
                  mem_wdata_q <= ip_data_wdata;
               end else if (grant_inst_d) begin
                  state_q     <= ST_INST;
                  last_q      <= OWN_INST;
                  first_q     <= 1'b0;
                  mem_req_q   <= 1'b1;
                  mem_wr_q    <= 1'b0;
                  mem_addr_q  <= ip_inst_addr;
                  mem_mask_q  <= INST_MASK;
                  mem_wdata_q <= 32'd0;
               end
            end
            ST_INST: begin
               if (mem_req_q && ip_mem_ack) begin
                  state_q      <= ST_IDLE;
                  mem_req_q    <= 1'b0;
                  inst_valid_q <= 1'b1;
                  inst_data_q  <= ip_mem_rdata;
               end
            end
            ST_DATA: begin
               if (mem_req_q && ip_mem_ack) begin
                  state_q      <= ST_IDLE;
                  mem_req_q    <= 1'b0;
                  data_valid_q <= 1'b1;
                  data_rdata_q <= ip_mem_rdata;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign op_mem_req    = mem_req_q;
   assign op_mem_wr     = mem_wr_q;
   assign op_mem_addr   = mem_addr_q;
   assign op_mem_mask   = mem_mask_q;
   assign op_mem_wdata  = mem_wdata_q;
   assign op_inst_valid = inst_valid_q;
   assign op_inst_data  = inst_data_q;
   assign op_data_valid = data_valid_q;
   assign op_data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks queue expected memory
// transactions, a responder model acks, and a cycle monitor checks the port.
module tb_mem_arbiter;

   localparam bit DF = 1'b1;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ip_inst_req;
   logic [31:0] ip_inst_addr;
   logic        op_inst_valid;
   logic [31:0] op_inst_data;
   logic        ip_data_rd, ip_data_wr;
   logic [31:0] ip_data_addr;
   logic [3:0]  ip_data_mask;
   logic [31:0] ip_data_wdata;
   logic        op_data_valid;
   logic [31:0] op_data_rdata;
   logic        op_mem_req, op_mem_wr;
   logic [31:0] op_mem_addr;
   logic [3:0]  op_mem_mask;
   logic [31:0] op_mem_wdata;
   logic        ip_mem_ack;
   logic [31:0] ip_mem_rdata;

   mem_arbiter #(.DATA_FIRST(DF)) dut (
      .clk(clk), .reset(reset),
      .ip_inst_req(ip_inst_req), .ip_inst_addr(ip_inst_addr),
      .op_inst_valid(op_inst_valid), .op_inst_data(op_inst_data),
      .ip_data_rd(ip_data_rd), .ip_data_wr(ip_data_wr),
      .ip_data_addr(ip_data_addr), .ip_data_mask(ip_data_mask),
      .ip_data_wdata(ip_data_wdata),
      .op_data_valid(op_data_valid), .op_data_rdata(op_data_rdata),
      .op_mem_req(op_mem_req), .op_mem_wr(op_mem_wr),
      .op_mem_addr(op_mem_addr), .op_mem_mask(op_mem_mask),
      .op_mem_wdata(op_mem_wdata),
      .ip_mem_ack(ip_mem_ack), .ip_mem_rdata(ip_mem_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   txn_t        qi[$], qd[$];
   logic [31:0] rsp_q[$];
   bit          glog[$];   // 1 = data owner

   // responder controls
   int          fixed_lat = -1;
   bit          fix_data  = 1'b0;
   logic [31:0] fix_val   = 32'd0;
   bit          rsp_hold  = 1'b0;
   bit          spur_req  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- memory responder ----------------
   initial begin : responder
      int cnt, lat;
      cnt = 0; lat = 0;
      ip_mem_ack = 1'b0; ip_mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         ip_mem_ack = 1'b0;
         if (reset) cnt = 0;
         else if (op_mem_req) begin
            if (!rsp_hold) begin
               if (cnt == 0) lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
               if (cnt == lat) begin
                  ip_mem_ack   = 1'b1;
                  ip_mem_rdata = fix_data ? fix_val : $urandom;
                  rsp_q.push_back(ip_mem_rdata);
                  cnt = 0;
               end else cnt++;
            end
         end else begin
            cnt = 0;
            if (spur_req) begin
               ip_mem_ack   = 1'b1;
               ip_mem_rdata = $urandom;
               spur_req     = 1'b0;
            end
         end
      end
   end

   // ---------------- reference model + monitor ----------------
   bit          m_busy, m_first, m_last_data, cur_data;
   txn_t        cur;
   logic [31:0] hold_i, hold_d, r;

   always @(posedge clk) begin
      bit p_i, p_d, own_d;
      #1;
      if (reset) begin
         m_busy = 0; m_first = 1; m_last_data = 0;
         hold_i = 0; hold_d = 0;
         qi.delete(); qd.delete(); rsp_q.delete();
      end else begin
         p_i = ip_inst_req;
         p_d = ip_data_rd | ip_data_wr;
         if (m_busy && ip_mem_ack) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_queue_nonempty", 0, 1);
               r = 32'hx;
            end else r = rsp_q.pop_front();
            chk("inst_valid_on_ack", {31'd0, op_inst_valid}, {31'd0, !cur_data});
            chk("data_valid_on_ack", {31'd0, op_data_valid}, {31'd0, cur_data});
            chk("mem_req_drops", {31'd0, op_mem_req}, 32'd0);
            if (cur_data) hold_d = r; else hold_i = r;
            m_busy = 0;
         end else begin
            chk("inst_valid_low", {31'd0, op_inst_valid}, 32'd0);
            chk("data_valid_low", {31'd0, op_data_valid}, 32'd0);
            if (!m_busy && (p_i || p_d)) begin
               own_d = (p_i && p_d) ? (m_first ? DF : !m_last_data) : p_d;
               if ((own_d ? qd.size() : qi.size()) == 0) begin
                  chk("expected_txn_queued", 0, 1);
                  cur = '0;
               end else cur = own_d ? qd.pop_front() : qi.pop_front();
               cur_data = own_d; m_last_data = own_d; m_first = 0; m_busy = 1;
               glog.push_back(own_d);
            end
            chk("mem_req_level", {31'd0, op_mem_req}, {31'd0, m_busy});
            if (m_busy) begin
               chk("mem_wr", {31'd0, op_mem_wr}, {31'd0, cur.wr});
               chk("mem_addr", op_mem_addr, cur.addr);
               chk("mem_mask", {28'd0, op_mem_mask}, {28'd0, cur.mask});
               if (cur_data) chk("mem_wdata", op_mem_wdata, cur.wdata);
            end
         end
         chk("inst_data_hold", op_inst_data, hold_i);
         chk("data_rdata_hold", op_data_rdata, hold_d);
      end
   end

   // ---------------- requester tasks ----------------
   task automatic inst_txn(input logic [31:0] a);
      bit got;
      @(negedge clk);
      ip_inst_req = 1'b1; ip_inst_addr = a;
      qi.push_back('{wr: 1'b0, addr: a, mask: 4'hF, wdata: 32'd0});
      got = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (op_inst_valid) begin got = 1; break; end
      end
      if (!got) chk("inst_txn_timeout", 0, 1);
      ip_inst_req = 1'b0;
   endtask

   task automatic data_txn(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [3:0] m, input logic [31:0] wd);
      bit got;
      @(negedge clk);
      ip_data_rd = rd; ip_data_wr = wr;
      ip_data_addr = a; ip_data_mask = m; ip_data_wdata = wd;
      qd.push_back('{wr: wr, addr: a, mask: m, wdata: wd});
      got = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (op_data_valid) begin got = 1; break; end
      end
      if (!got) chk("data_txn_timeout", 0, 1);
      ip_data_rd = 1'b0; ip_data_wr = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int vcnt;
      bit got;
      reset = 1'b1;
      ip_inst_req = 0; ip_inst_addr = 0;
      ip_data_rd = 0; ip_data_wr = 0; ip_data_addr = 0; ip_data_mask = 0; ip_data_wdata = 0;
      repeat (3) @(negedge clk);
      chk("rst_mem_req", {31'd0, op_mem_req}, 32'd0);
      chk("rst_mem_wr", {31'd0, op_mem_wr}, 32'd0);
      chk("rst_mem_addr", op_mem_addr, 32'd0);
      chk("rst_mem_wdata", op_mem_wdata, 32'd0);
      chk("rst_mem_mask", {28'd0, op_mem_mask}, 32'd0);
      chk("rst_inst_valid", {31'd0, op_inst_valid}, 32'd0);
      chk("rst_data_valid", {31'd0, op_data_valid}, 32'd0);
      chk("rst_inst_data", op_inst_data, 32'd0);
      chk("rst_data_rdata", op_data_rdata, 32'd0);
      reset = 1'b0;

      // simultaneous requests after reset, held over four transactions
      glog.delete();
      fork
         begin inst_txn(32'h104); inst_txn(32'h108); end
         begin data_txn(1, 0, 32'h2000, 4'hF, 32'd0); data_txn(1, 0, 32'h2004, 4'hF, 32'd0); end
      join
      chk("fair_count", glog.size(), 4);
      if (glog.size() == 4) begin
         chk("fair_0_data", {31'd0, glog[0]}, 32'd1);
         chk("fair_1_inst", {31'd0, glog[1]}, 32'd0);
         chk("fair_2_data", {31'd0, glog[2]}, 32'd1);
         chk("fair_3_inst", {31'd0, glog[3]}, 32'd0);
      end

      // instruction fetch, ack two cycles after op_mem_req
      fixed_lat = 2; fix_data = 1; fix_val = 32'h00500093;
      inst_txn(32'h100);
      chk("fetch_word", op_inst_data, 32'h00500093);
      fix_data = 0;

      // store with a long ack latency so the field-hold window is exercised
      fixed_lat = 3;
      data_txn(0, 1, 32'h2003, 4'b1000, 32'hAB000000);
      // rd and wr together behave as a store
      data_txn(1, 1, 32'h2010, 4'b0011, 32'h0000BEEF);

      // spurious ack in idle, then a fetch must still be granted at once
      fixed_lat = 0;
      @(negedge clk); spur_req = 1;
      repeat (4) @(negedge clk);
      inst_txn(32'h200);

      // minimum round trip, back-to-back from both sides
      fork
         begin inst_txn(32'h300); inst_txn(32'h304); inst_txn(32'h308); end
         begin data_txn(1, 0, 32'h4000, 4'h1, 32'd0); data_txn(0, 1, 32'h4004, 4'h2, 32'h12345678); end
      join

      // randomized traffic
      fixed_lat = -1;
      fork
         for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            inst_txn({$urandom_range(0, 32'hFFFF), 2'b00});
         end
         for (int k = 0; k < 12; k++) begin
            bit w, rdb;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w = 1'($urandom_range(0, 1));
            rdb = w ? 1'($urandom_range(0, 1)) : 1'b1;
            data_txn(rdb, w, $urandom, 4'($urandom_range(1, 15)), $urandom);
         end
      join

      // reset in the middle of a data transaction, then a late ack
      rsp_hold = 1;
      @(negedge clk);
      ip_data_rd = 1; ip_data_addr = 32'h3000; ip_data_mask = 4'hF; ip_data_wdata = 0;
      qd.push_back('{wr: 1'b0, addr: 32'h3000, mask: 4'hF, wdata: 32'd0});
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (op_mem_req) begin got = 1; break; end
      end
      chk("rst_mid_req_seen", {31'd0, got}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_mid_req_low", {31'd0, op_mem_req}, 32'd0);
      chk("rst_mid_addr_zero", op_mem_addr, 32'd0);
      chk("rst_mid_data_valid", {31'd0, op_data_valid}, 32'd0);
      ip_data_rd = 0;
      @(negedge clk); reset = 1'b0; rsp_hold = 0; spur_req = 1;
      vcnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (op_data_valid || op_inst_valid) vcnt++;
      end
      chk("late_ack_no_valid", vcnt, 0);
      data_txn(1, 0, 32'h5000, 4'hF, 32'd0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
